odd_even_sort_pipe: RTL

Parametrised, fully pipelined odd-even transposition sorter with valid/ready flow control and a per-vector sort direction. It accepts one vector of N unsigned K-bit keys per cycle and emits the sorted vector N+1 cycles later. It tracks the number of vectors in flight and, as a build option, the original position of every key. It sits between a producer stream and a consumer stream, both of which may stall.

---
 rtl/odd_even_sort_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/odd_even_sort_pipe.sv
// odd_even_sort_pipe: fully pipelined odd-even transposition sorter.
// One capture slot (S0) followed by N compare-exchange stages (S1..SN).
// Each vector carries its own sort direction. A single global enable
// freezes the whole pipe while the consumer stalls a valid output.
// Build option: define SORT_IDX_EN to carry the original key positions
// through the pipe and expose them on out_idx.
module odd_even_sort_pipe #(
    parameter int N = 8,
    parameter int K = 8,
`ifdef SORT_IDX_EN
    localparam int IW = $clog2(N),
`endif
    localparam int CW = $clog2(N + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_dir,
    input  logic [N*K-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*K-1:0]  out_data,
    output logic            out_dir,
`ifdef SORT_IDX_EN
    output logic [N*IW-1:0] out_idx,
`endif
    output logic [CW-1:0]   count
);

    // Registered contents of every slot, indexed by stage number.
    logic [N*K-1:0]  slot_data  [0:N];
    logic            slot_dir   [0:N];
    logic            slot_valid [0:N];
`ifdef SORT_IDX_EN
    logic [N*IW-1:0] slot_idx   [0:N];
`endif

    logic en;
    logic in_acc;
    logic out_acc;

    // Whole pipe advances unless a valid output is being held back.
    assign en        = out_ready | ~out_valid;
    assign in_ready  = en & ~rst;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;

    assign out_valid = slot_valid[N];
    assign out_data  = slot_data[N];
    assign out_dir   = slot_dir[N];
`ifdef SORT_IDX_EN
    assign out_idx   = slot_idx[N];
`endif

    genvar gi;
    generate
        for (gi = 0; gi <= N; gi++) begin : g_slot
            logic [N*K-1:0]  src_data;
            logic            src_dir;
            logic            src_valid;
            logic [N*K-1:0]  data_q, data_d;
            logic            dir_q, dir_d;
            logic            valid_q, valid_d;
`ifdef SORT_IDX_EN
            logic [N*IW-1:0] src_idx;
            logic [N*IW-1:0] idx_q, idx_d;
`endif

            if (gi == 0) begin : g_src
                // Capture slot: raw input vector, indices start as identity.
                always_comb begin
                    src_data  = in_data;
                    src_dir   = in_dir;
                    src_valid = in_valid;
`ifdef SORT_IDX_EN
                    src_idx   = '0;
                    for (int j = 0; j < N; j++) begin
                        src_idx[j*IW +: IW] = IW'(j);
                    end
`endif
                end
            end else begin : g_src
                // Compare-exchange: even phases pair (0,1),(2,3)..., odd
                // phases pair (1,2),(3,4)...; strict compare keeps ties stable.
                always_comb begin
                    src_data  = slot_data[gi-1];
                    src_dir   = slot_dir[gi-1];
                    src_valid = slot_valid[gi-1];
`ifdef SORT_IDX_EN
                    src_idx   = slot_idx[gi-1];
`endif
                    for (int j = (gi - 1) % 2; j + 1 < N; j += 2) begin
                        if (slot_dir[gi-1] ?
                                (slot_data[gi-1][j*K +: K] < slot_data[gi-1][(j+1)*K +: K]) :
                                (slot_data[gi-1][j*K +: K] > slot_data[gi-1][(j+1)*K +: K])) begin
                            src_data[j*K +: K]     = slot_data[gi-1][(j+1)*K +: K];
                            src_data[(j+1)*K +: K] = slot_data[gi-1][j*K +: K];
`ifdef SORT_IDX_EN
                            src_idx[j*IW +: IW]     = slot_idx[gi-1][(j+1)*IW +: IW];
                            src_idx[(j+1)*IW +: IW] = slot_idx[gi-1][j*IW +: IW];
`endif
                        end
                    end
                end
            end

            // Shift in the upstream result when enabled, otherwise hold.
            always_comb begin
                data_d  = data_q;
                dir_d   = dir_q;
                valid_d = valid_q;
`ifdef SORT_IDX_EN
                idx_d   = idx_q;
`endif
                if (en) begin
                    data_d  = src_data;
                    dir_d   = src_dir;
                    valid_d = src_valid;
`ifdef SORT_IDX_EN
                    idx_d   = src_idx;
`endif
                end
            end

            // Slot register; reset clears contents so in-flight vectors vanish.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    dir_q   <= 1'b0;
                    valid_q <= 1'b0;
`ifdef SORT_IDX_EN
                    idx_q   <= '0;
`endif
                end else begin
                    data_q  <= data_d;
                    dir_q   <= dir_d;
                    valid_q <= valid_d;
`ifdef SORT_IDX_EN
                    idx_q   <= idx_d;
`endif
                end
            end

            assign slot_data[gi]  = data_q;
            assign slot_dir[gi]   = dir_q;
            assign slot_valid[gi] = valid_q;
`ifdef SORT_IDX_EN
            assign slot_idx[gi]   = idx_q;
`endif
        end
    endgenerate

    logic [CW-1:0] count_q, count_d;

    // Occupancy: +1 on input handshake, -1 on output handshake, both cancel.
    always_comb begin
        count_d = count_q;
        if (in_acc && !out_acc) begin
            count_d = count_q + CW'(1);
        end else if (!in_acc && out_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
